// File: rtl/axi_read_arbiter_if.sv
// Purpose: bundles the AXI read master channels and the per-port reader request/data buses.
// Latency: none (signal container only).
// Backpressure: carries arready/rready and per-port rdy signals; no buffering.
interface axi_read_arbiter_if #(
   parameter int NUM_PORTS = 4,
   parameter int PORT_BITS = 2,
   parameter int ID_W      = 8,
   parameter int ADDR_W    = 32,
   parameter int LEN_W     = 8,
   parameter int DATA_W    = 256
);
   // AXI AR channel
   logic                                    axi_arready_in;
   logic [ID_W-1:0]                         axi_arid_out;
   logic [ADDR_W-1:0]                       axi_araddr_out;
   logic [LEN_W-1:0]                        axi_arlen_out;
   logic                                    axi_arvalid_out;
   // AXI R channel
   logic [ID_W-1:0]                         axi_rid_in;
   logic [DATA_W-1:0]                       axi_rdata_in;
   logic                                    axi_rlast_in;
   logic                                    axi_rvalid_in;
   logic                                    axi_rready_out;
   // reader ports
   logic [NUM_PORTS-1:0]                    active_ports_in;
   logic [NUM_PORTS*(ID_W-PORT_BITS)-1:0]   rd_id_in;
   logic [NUM_PORTS*ADDR_W-1:0]             rd_addr_in;
   logic [NUM_PORTS*LEN_W-1:0]              rd_len_in;
   logic [NUM_PORTS-1:0]                    rd_info_valid_in;
   logic [NUM_PORTS-1:0]                    rd_info_rdy_out;
   logic [DATA_W-1:0]                       rd_data_out;
   logic                                    rd_data_last_out;
   logic [NUM_PORTS-1:0]                    rd_data_valid_out;
   logic [NUM_PORTS-1:0]                    rd_data_rdy_in;
   logic                                    bad_rid_out;

   // arbiter side: drives the AXI master outputs and the reader responses
   modport master (
      input  axi_arready_in, axi_rid_in, axi_rdata_in, axi_rlast_in, axi_rvalid_in,
      input  active_ports_in, rd_id_in, rd_addr_in, rd_len_in, rd_info_valid_in, rd_data_rdy_in,
      output axi_arid_out, axi_araddr_out, axi_arlen_out, axi_arvalid_out, axi_rready_out,
      output rd_info_rdy_out, rd_data_out, rd_data_last_out, rd_data_valid_out, bad_rid_out
   );

   // environment side: readers plus the downstream AXI slave
   modport slave (
      output axi_arready_in, axi_rid_in, axi_rdata_in, axi_rlast_in, axi_rvalid_in,
      output active_ports_in, rd_id_in, rd_addr_in, rd_len_in, rd_info_valid_in, rd_data_rdy_in,
      input  axi_arid_out, axi_araddr_out, axi_arlen_out, axi_arvalid_out, axi_rready_out,
      input  rd_info_rdy_out, rd_data_out, rd_data_last_out, rd_data_valid_out, bad_rid_out
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// Purpose: round-robin share of one AXI read master among NUM_PORTS readers, R beats routed by RID tag.
// Latency: grant pulse in cycle t, registered AR valid from t+1; R path is zero-latency combinational.
// Backpressure: AR held stable until arready; rready follows the tagged port's rdy; bursts capped per port.
module axi_read_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int PORT_BITS       = 2,
   parameter int ID_W            = 8,
   parameter int ADDR_W          = 32,
   parameter int LEN_W           = 8,
   parameter int DATA_W          = 256,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3
) (
   input logic                clk,
   input logic                rst,
   axi_read_arbiter_if.master bus
);
   localparam int LID_W = ID_W - PORT_BITS;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t               state;
   logic [PORT_BITS-1:0] ptr;
   logic [PORT_BITS-1:0] gnt_q;
   logic [PORT_BITS-1:0] gnt_idx;
   logic [PORT_BITS-1:0] cand;
   logic                 gnt_found;
   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] inc_vec;
   logic [NUM_PORTS-1:0] dec_vec;
   logic [CNT_W-1:0]     outstanding [NUM_PORTS];
   logic [PORT_BITS-1:0] tag;
   logic                 tag_ok;
   logic                 r_done;
   logic [DATA_W-1:0]    r_dat;
   logic                 unused_rid_local;

   // a port may be granted only while enabled, requesting and below its burst cap
   always_comb begin
      eligible = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         eligible[p] = bus.rd_info_valid_in[p] & bus.active_ports_in[p]
                       & (outstanding[p] < CNT_W'(MAX_OUTSTANDING));
      end
   end

   // first eligible port scanning upward from ptr, wrapping at NUM_PORTS
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int off = 0; off < NUM_PORTS; off++) begin
         cand = PORT_BITS'((int'(ptr) + off) % NUM_PORTS);
         if (!gnt_found && eligible[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign bus.rd_info_rdy_out = (!rst && state == IDLE && gnt_found)
                                ? (NUM_PORTS'(1) << gnt_idx) : '0;

   // grant/issue FSM owning the registered AR channel and the priority pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         ptr                 <= '0;
         gnt_q               <= '0;
         bus.axi_arvalid_out <= 1'b0;
         bus.axi_arid_out    <= '0;
         bus.axi_araddr_out  <= '0;
         bus.axi_arlen_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_found) begin
                  gnt_q               <= gnt_idx;
                  bus.axi_arid_out    <= {gnt_idx, bus.rd_id_in[gnt_idx*LID_W +: LID_W]};
                  bus.axi_araddr_out  <= bus.rd_addr_in[gnt_idx*ADDR_W +: ADDR_W];
                  bus.axi_arlen_out   <= bus.rd_len_in[gnt_idx*LEN_W +: LEN_W];
                  bus.axi_arvalid_out <= 1'b1;
                  state               <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.axi_arready_in) begin
                  bus.axi_arvalid_out <= 1'b0;
                  ptr   <= (gnt_q == PORT_BITS'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // R routing: the upper RID bits select the port; unknown tags are sunk
   assign tag              = bus.axi_rid_in[ID_W-1 -: PORT_BITS];
   assign tag_ok           = ({1'b0, tag} < (PORT_BITS + 1)'(NUM_PORTS));
   assign bus.rd_data_valid_out = tag_ok ? (NUM_PORTS'(bus.axi_rvalid_in) << tag) : '0;
   assign bus.axi_rready_out    = tag_ok ? bus.rd_data_rdy_in[tag] : 1'b1;
   assign r_dat                 = bus.axi_rdata_in;
   assign bus.rd_data_out       = r_dat;
   assign bus.rd_data_last_out  = bus.axi_rlast_in;
   assign r_done = bus.axi_rvalid_in & bus.axi_rready_out & bus.axi_rlast_in & tag_ok;
   // the port-local ID bits are meaningful only to the reader, not to routing
   assign unused_rid_local = ^bus.axi_rid_in[LID_W-1:0];

   // per-port burst start (AR accepted) and burst end (last beat taken) events
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         inc_vec[p] = (state == ISSUE) & bus.axi_arready_in & (gnt_q == PORT_BITS'(p));
         dec_vec[p] = r_done & (tag == PORT_BITS'(p));
      end
   end

   // outstanding counters: simultaneous start/end cancels, no wrap in either direction
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) outstanding[p] <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (inc_vec[p] && !dec_vec[p] && outstanding[p] != '1)
               outstanding[p] <= outstanding[p] + 1'b1;
            else if (dec_vec[p] && !inc_vec[p] && outstanding[p] != '0)
               outstanding[p] <= outstanding[p] - 1'b1;
         end
      end
   end

   // sticky flag for any valid beat carrying a tag beyond the configured ports
   always_ff @(posedge clk) begin
      if (rst)
         bus.bad_rid_out <= 1'b0;
      else if (bus.axi_rvalid_in && !tag_ok)
         bus.bad_rid_out <= 1'b1;
   end
endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   axi_read_arbiter_if #(.NUM_PORTS(4), .PORT_BITS(2), .ID_W(8), .ADDR_W(32), .LEN_W(8), .DATA_W(256)) b4 ();
   axi_read_arbiter_if #(.NUM_PORTS(3), .PORT_BITS(2), .ID_W(8), .ADDR_W(32), .LEN_W(8), .DATA_W(256)) b3 ();

   axi_read_arbiter #(.NUM_PORTS(4), .PORT_BITS(2), .ID_W(8), .ADDR_W(32), .LEN_W(8), .DATA_W(256),
                      .MAX_OUTSTANDING(4), .CNT_W(3))
      dut4 (.clk(clk), .rst(rst), .bus(b4));

   axi_read_arbiter #(.NUM_PORTS(3), .PORT_BITS(2), .ID_W(8), .ADDR_W(32), .LEN_W(8), .DATA_W(256),
                      .MAX_OUTSTANDING(2), .CNT_W(2))
      dut3 (.clk(clk), .rst(rst), .bus(b3));

   task automatic idle_inputs();
      b4.active_ports_in = '1;  b4.axi_arready_in = 1'b0; b4.axi_rid_in = '0; b4.axi_rdata_in = '0;
      b4.axi_rlast_in = 1'b0;   b4.axi_rvalid_in = 1'b0;  b4.rd_id_in = '0;   b4.rd_addr_in = '0;
      b4.rd_len_in = '0;        b4.rd_info_valid_in = '0; b4.rd_data_rdy_in = '1;
      b3.active_ports_in = '1;  b3.axi_arready_in = 1'b0; b3.axi_rid_in = '0; b3.axi_rdata_in = '0;
      b3.axi_rlast_in = 1'b0;   b3.axi_rvalid_in = 1'b0;  b3.rd_id_in = '0;   b3.rd_addr_in = '0;
      b3.rd_len_in = '0;        b3.rd_info_valid_in = '0; b3.rd_data_rdy_in = '1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      b4.rd_info_valid_in = '1;
      b3.rd_info_valid_in = '1;
      repeat (2) @(negedge clk);
      #1;
      n_vec++; if (b4.rd_info_rdy_out !== 4'b0000) begin n_err++; $display("FAIL reset_rdy4: got %b want 0000", b4.rd_info_rdy_out); end
      n_vec++; if (b3.rd_info_rdy_out !== 3'b000) begin n_err++; $display("FAIL reset_rdy3: got %b want 000", b3.rd_info_rdy_out); end
      n_vec++; if (b4.axi_arvalid_out !== 1'b0) begin n_err++; $display("FAIL reset_arvalid: got %b want 0", b4.axi_arvalid_out); end
      n_vec++; if ({b4.axi_arid_out, b4.axi_araddr_out, b4.axi_arlen_out} !== 48'h0) begin n_err++;
         $display("FAIL reset_ar_fields: got %h want 0", {b4.axi_arid_out, b4.axi_araddr_out, b4.axi_arlen_out}); end
      n_vec++; if (b3.bad_rid_out !== 1'b0) begin n_err++; $display("FAIL reset_bad_rid: got %b want 0", b3.bad_rid_out); end
      n_vec++; if (b4.rd_data_valid_out !== 4'b0000) begin n_err++; $display("FAIL reset_rvalid: got %b want 0000", b4.rd_data_valid_out); end
      rst = 1'b0;
      b4.rd_info_valid_in = '0;
      b3.rd_info_valid_in = '0;
   endtask

   task automatic test_single();
      logic [31:0]  w;
      logic [255:0] exp_dat;
      do_reset();
      @(negedge clk);
      b4.rd_info_valid_in = 4'b0001; b4.rd_id_in[5:0] = 6'd5; b4.rd_addr_in[31:0] = 32'h1000;
      b4.rd_len_in[7:0] = 8'd3;      b4.axi_arready_in = 1'b1;
      #1;
      n_vec++; if (b4.rd_info_rdy_out !== 4'b0001) begin n_err++; $display("FAIL single_rdy: got %b want 0001", b4.rd_info_rdy_out); end
      n_vec++; if (b4.axi_arvalid_out !== 1'b0) begin n_err++; $display("FAIL single_arvalid_t: got %b want 0", b4.axi_arvalid_out); end
      @(negedge clk);
      b4.rd_info_valid_in = 4'b0000;
      #1;
      n_vec++; if ({b4.axi_arvalid_out, b4.axi_arid_out, b4.axi_araddr_out, b4.axi_arlen_out} !== {1'b1, 8'h05, 32'h1000, 8'd3}) begin
         n_err++; $display("FAIL single_ar: got v%b id%h a%h l%h want v1 id05 a00001000 l03",
                           b4.axi_arvalid_out, b4.axi_arid_out, b4.axi_araddr_out, b4.axi_arlen_out); end
      @(negedge clk);
      b4.axi_arready_in = 1'b0;
      #1;
      n_vec++; if (b4.axi_arvalid_out !== 1'b0) begin n_err++; $display("FAIL single_arvalid_clr: got %b want 0", b4.axi_arvalid_out); end
      n_vec++; if (dut4.outstanding[0] !== 3'd1) begin n_err++; $display("FAIL single_cnt_up: got %0d want 1", dut4.outstanding[0]); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         w = 32'hA0B0_0000 + i;
         exp_dat = {8{w}};
         b4.axi_rid_in = 8'h05; b4.axi_rvalid_in = 1'b1; b4.axi_rlast_in = (i == 3); b4.axi_rdata_in = exp_dat;
         #1;
         n_vec++; if ({b4.rd_data_valid_out, b4.axi_rready_out, b4.rd_data_last_out} !== {4'b0001, 1'b1, (i == 3)}) begin
            n_err++; $display("FAIL single_beat%0d: got valid %b rready %b last %b want 0001 1 %b",
                              i, b4.rd_data_valid_out, b4.axi_rready_out, b4.rd_data_last_out, (i == 3)); end
         n_vec++; if (b4.rd_data_out !== exp_dat) begin n_err++; $display("FAIL single_data%0d: got %h want %h", i, b4.rd_data_out[31:0], w); end
      end
      @(negedge clk);
      b4.axi_rvalid_in = 1'b0; b4.axi_rlast_in = 1'b0;
      #1;
      n_vec++; if (b4.rd_data_valid_out !== 4'b0000) begin n_err++; $display("FAIL single_rquiet: got %b want 0000", b4.rd_data_valid_out); end
      n_vec++; if (dut4.outstanding[0] !== 3'd0) begin n_err++; $display("FAIL single_cnt_down: got %0d want 0", dut4.outstanding[0]); end
   endtask

   task automatic test_round_robin();
      int         g;
      logic [3:0] exp_rdy;
      logic [7:0] exp_id;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            b4.rd_info_valid_in = 4'b1111; b4.axi_arready_in = 1'b1;
            for (int p = 0; p < 4; p++) b4.rd_id_in[p*6 +: 6] = 6'(p + 8);
         end
         #1;
         g = (i / 2) % 4;
         exp_rdy = (i % 2 == 0) ? (4'b0001 << g) : 4'b0000;
         n_vec++; if (b4.rd_info_rdy_out !== exp_rdy) begin n_err++; $display("FAIL rr_rdy%0d: got %b want %b", i, b4.rd_info_rdy_out, exp_rdy); end
         if (i % 2 == 1) begin
            exp_id = {2'(g), 6'(g + 8)};
            n_vec++; if ({b4.axi_arvalid_out, b4.axi_arid_out} !== {1'b1, exp_id}) begin
               n_err++; $display("FAIL rr_arid%0d: got v%b %h want v1 %h", i, b4.axi_arvalid_out, b4.axi_arid_out, exp_id); end
         end
      end
   endtask

   task automatic test_active_mask();
      int         seq [4] = '{1, 3, 1, 3};
      logic [3:0] exp_rdy;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin
            b4.active_ports_in = 4'b1010; b4.rd_info_valid_in = 4'b1111; b4.axi_arready_in = 1'b1;
         end
         #1;
         exp_rdy = (i % 2 == 0) ? (4'b0001 << seq[i/2]) : 4'b0000;
         n_vec++; if (b4.rd_info_rdy_out !== exp_rdy) begin n_err++; $display("FAIL mask_rdy%0d: got %b want %b", i, b4.rd_info_rdy_out, exp_rdy); end
      end
   endtask

   task automatic test_limit();
      logic [2:0] exp_rdy;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            b3.rd_info_valid_in = 3'b100; b3.rd_id_in[17:12] = 6'h11; b3.axi_arready_in = 1'b1;
         end
         b3.axi_rid_in    = {2'd2, 6'h11};
         b3.axi_rvalid_in = (i == 6 || i == 8);
         b3.axi_rlast_in  = (i == 6 || i == 8);
         #1;
         exp_rdy = (i == 0 || i == 2 || i == 7 || i == 9) ? 3'b100 : 3'b000;
         n_vec++; if (b3.rd_info_rdy_out !== exp_rdy) begin n_err++; $display("FAIL limit_rdy%0d: got %b want %b", i, b3.rd_info_rdy_out, exp_rdy); end
         if (i == 5) begin
            n_vec++; if (dut3.outstanding[2] !== 2'd2) begin n_err++; $display("FAIL limit_cnt_full: got %0d want 2", dut3.outstanding[2]); end
         end
         if (i == 6) begin
            n_vec++; if ({b3.rd_data_valid_out, b3.axi_rready_out} !== {3'b100, 1'b1}) begin
               n_err++; $display("FAIL limit_rroute: got %b %b want 100 1", b3.rd_data_valid_out, b3.axi_rready_out); end
         end
         if (i == 9) begin
            n_vec++; if (dut3.outstanding[2] !== 2'd1) begin n_err++; $display("FAIL limit_cnt_coincide: got %0d want 1", dut3.outstanding[2]); end
         end
      end
   endtask

   task automatic test_arready_stall();
      logic [3:0] exp_rdy;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 0) begin
            b4.rd_info_valid_in = 4'b1111;
            b4.rd_id_in[5:0] = 6'h2A; b4.rd_addr_in[31:0] = 32'hDEAD_BEE0; b4.rd_len_in[7:0] = 8'd7;
            b4.rd_id_in[11:6] = 6'h15; b4.rd_addr_in[63:32] = 32'h0000_2000; b4.rd_len_in[15:8] = 8'd1;
         end
         b4.axi_arready_in = (i == 6);
         b4.axi_rid_in     = {2'd1, 6'h00};
         b4.axi_rvalid_in  = (i == 3);
         b4.rd_data_rdy_in = (i == 3) ? 4'b1101 : 4'b1111;
         #1;
         exp_rdy = (i == 0) ? 4'b0001 : ((i == 7) ? 4'b0010 : 4'b0000);
         n_vec++; if (b4.rd_info_rdy_out !== exp_rdy) begin n_err++; $display("FAIL stall_rdy%0d: got %b want %b", i, b4.rd_info_rdy_out, exp_rdy); end
         if (i >= 1 && i <= 6) begin
            n_vec++; if ({b4.axi_arvalid_out, b4.axi_arid_out, b4.axi_araddr_out, b4.axi_arlen_out} !== {1'b1, 8'h2A, 32'hDEAD_BEE0, 8'd7}) begin
               n_err++; $display("FAIL stall_ar%0d: got v%b id%h a%h l%h want v1 id2a adeadbee0 l07",
                                 i, b4.axi_arvalid_out, b4.axi_arid_out, b4.axi_araddr_out, b4.axi_arlen_out); end
         end
         if (i == 3) begin
            n_vec++; if ({b4.axi_rready_out, b4.rd_data_valid_out} !== {1'b0, 4'b0010}) begin
               n_err++; $display("FAIL stall_rready: got %b %b want 0 0010", b4.axi_rready_out, b4.rd_data_valid_out); end
         end
      end
   endtask

   task automatic test_bad_rid();
      do_reset();
      @(negedge clk);
      b3.axi_rid_in = {2'd3, 6'h07}; b3.axi_rvalid_in = 1'b0;
      #1;
      @(negedge clk);
      #1;
      n_vec++; if (b3.bad_rid_out !== 1'b0) begin n_err++; $display("FAIL bad_no_valid: got %b want 0", b3.bad_rid_out); end
      b3.axi_rvalid_in = 1'b1; b3.axi_rlast_in = 1'b1; b3.rd_data_rdy_in = 3'b000;
      #1;
      n_vec++; if ({b3.axi_rready_out, b3.rd_data_valid_out} !== {1'b1, 3'b000}) begin
         n_err++; $display("FAIL bad_sink: got %b %b want 1 000", b3.axi_rready_out, b3.rd_data_valid_out); end
      @(negedge clk);
      b3.axi_rvalid_in = 1'b0; b3.axi_rlast_in = 1'b0;
      #1;
      n_vec++; if (b3.bad_rid_out !== 1'b1) begin n_err++; $display("FAIL bad_set: got %b want 1", b3.bad_rid_out); end
      repeat (3) @(negedge clk);
      #1;
      n_vec++; if (b3.bad_rid_out !== 1'b1) begin n_err++; $display("FAIL bad_sticky: got %b want 1", b3.bad_rid_out); end
      do_reset();
      #1;
      n_vec++; if (b3.bad_rid_out !== 1'b0) begin n_err++; $display("FAIL bad_cleared: got %b want 0", b3.bad_rid_out); end
   endtask

   task automatic test_reset_mid_issue();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 0) begin b4.rd_info_valid_in = 4'b0010; b4.axi_arready_in = 1'b1; end
         if (i == 5) begin b4.axi_arready_in = 1'b0; rst = 1'b1; end
         if (i == 6) begin rst = 1'b0; b4.rd_info_valid_in = 4'b0000; end
         b4.axi_rid_in    = {2'd1, 6'h00};
         b4.axi_rvalid_in = (i == 7);
         b4.axi_rlast_in  = (i == 7);
         #1;
         if (i == 5) begin
            n_vec++; if ({b4.axi_arvalid_out, dut4.outstanding[1]} !== {1'b1, 3'd2}) begin
               n_err++; $display("FAIL mid_pre: got v%b cnt%0d want v1 cnt2", b4.axi_arvalid_out, dut4.outstanding[1]); end
         end
         if (i == 6) begin
            n_vec++; if ({b4.axi_arvalid_out, dut4.ptr, dut4.outstanding[1], b4.bad_rid_out} !== {1'b0, 2'd0, 3'd0, 1'b0}) begin
               n_err++; $display("FAIL mid_reset: got v%b ptr%0d cnt%0d bad%b want v0 ptr0 cnt0 bad0",
                                 b4.axi_arvalid_out, dut4.ptr, dut4.outstanding[1], b4.bad_rid_out); end
         end
         if (i == 7) begin
            n_vec++; if (b4.rd_data_valid_out !== 4'b0010) begin n_err++; $display("FAIL mid_route: got %b want 0010", b4.rd_data_valid_out); end
         end
         if (i == 8) begin
            n_vec++; if (dut4.outstanding[1] !== 3'd0) begin n_err++; $display("FAIL mid_saturate: got %0d want 0", dut4.outstanding[1]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_active_mask();
      test_limit();
      test_arready_stall();
      test_bad_rid();
      test_reset_mid_issue();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
